// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width,
// default reset PC and the fetch state encoding.
package fetch_unit_pkg;

    localparam int FETCH_WORD_SIZE = 16;
    localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_FETCH = 3'd1,
        FS_SKID  = 3'd2,
        FS_KILL  = 3'd3,
        FS_HALT  = 3'd4
    } fetch_state_t;

    // States in which a memory read is on the bus and must run to completion.
    function automatic logic state_has_request(input fetch_state_t state);
        return (state == FS_FETCH) || (state == FS_KILL);
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry holding register for an instruction and its PC, used when a
// memory read completes while the IF/ID slot is full and stalled.
module fetch_skid #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] load_instr,
    input  logic [WIDTH-1:0] load_pc,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc,
    output logic             full
);

    // Entry storage: clear beats load, load beats unload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= {WIDTH{1'b0}};
            pc    <= {WIDTH{1'b0}};
            full  <= 1'b0;
        end else if (clear) begin
            instr <= {WIDTH{1'b0}};
            pc    <= {WIDTH{1'b0}};
            full  <= 1'b0;
        end else if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
            full  <= 1'b1;
        end else if (unload) begin
            full  <= 1'b0;
        end else begin
            full  <= full;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory read
// handshake and presents one instruction per cycle to the IF/ID boundary.
// Redirects from EX and halt from ID are absorbed without ever abandoning
// a memory request that is already on the bus.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   WORD_SIZE = FETCH_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = FETCH_RESET_PC
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    output logic                 readM1,
    output logic [WORD_SIZE-1:0] address1,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic                 mem_ready,
    input  logic                 id_stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_target,
    input  logic                 halt,
    output logic                 if_valid,
    output logic [WORD_SIZE-1:0] if_instr,
    output logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] if_pc_next,
    output logic [WORD_SIZE-1:0] num_fetched,
    output logic                 is_halted
);

    fetch_state_t         state_r;
    logic [WORD_SIZE-1:0] pc_r;
    logic                 halt_pending_r;

    logic                 redirect_s;
    logic                 halt_s;
    logic                 consume_s;
    logic                 slot_free_s;
    logic                 pending_s;
    logic                 skid_clear_s;
    logic                 skid_load_s;
    logic                 skid_unload_s;
    logic [WORD_SIZE-1:0] skid_instr_s;
    logic [WORD_SIZE-1:0] skid_pc_s;
    logic                 skid_full_s;

    // Event decode: redirect outranks halt, and both are ignored once halted.
    always_comb begin
        redirect_s    = redirect && (state_r != FS_HALT);
        halt_s        = halt && !redirect_s && (state_r != FS_HALT);
        consume_s     = if_valid && !id_stall;
        slot_free_s   = !if_valid || !id_stall;
        pending_s     = state_has_request(state_r) && !mem_ready;
        skid_clear_s  = redirect_s || halt_s;
        skid_load_s   = (state_r == FS_FETCH) && !skid_clear_s && mem_ready && !slot_free_s;
        skid_unload_s = (state_r == FS_SKID) && !skid_clear_s && skid_full_s && !id_stall;
    end

    fetch_skid #(
        .WIDTH (WORD_SIZE)
    ) u_skid (
        .clk        (Clk),
        .rst_n      (Reset_N),
        .clear      (skid_clear_s),
        .load       (skid_load_s),
        .unload     (skid_unload_s),
        .load_instr (data1),
        .load_pc    (pc_r),
        .instr      (skid_instr_s),
        .pc         (skid_pc_s),
        .full       (skid_full_s)
    );

    // Fetch FSM with PC, memory request and IF/ID outputs all registered.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_r        <= FS_IDLE;
            pc_r           <= RESET_PC;
            halt_pending_r <= 1'b0;
            readM1         <= 1'b0;
            address1       <= {WORD_SIZE{1'b0}};
            if_valid       <= 1'b0;
            if_instr       <= {WORD_SIZE{1'b0}};
            if_pc          <= {WORD_SIZE{1'b0}};
            if_pc_next     <= {WORD_SIZE{1'b0}};
            num_fetched    <= {WORD_SIZE{1'b0}};
            is_halted      <= 1'b0;
        end else begin
            // Instructions taken by ID on a redirect edge are wrong-path.
            if (consume_s && !redirect_s) begin
                num_fetched <= num_fetched + WORD_SIZE'(1);
            end else begin
                num_fetched <= num_fetched;
            end

            if (redirect_s) begin
                pc_r           <= redirect_target;
                if_valid       <= 1'b0;
                halt_pending_r <= 1'b0;
                readM1         <= 1'b1;
                if (pending_s) begin
                    // Outstanding read keeps its address; its data is dropped.
                    state_r <= FS_KILL;
                end else begin
                    state_r  <= FS_FETCH;
                    address1 <= redirect_target;
                end
            end else if (halt_s) begin
                if_valid <= 1'b0;
                if (pending_s) begin
                    state_r        <= FS_KILL;
                    halt_pending_r <= 1'b1;
                    readM1         <= 1'b1;
                end else begin
                    state_r   <= FS_HALT;
                    readM1    <= 1'b0;
                    is_halted <= 1'b1;
                end
            end else begin
                case (state_r)
                    FS_IDLE: begin
                        state_r  <= FS_FETCH;
                        readM1   <= 1'b1;
                        address1 <= pc_r;
                    end
                    FS_FETCH: begin
                        if (mem_ready) begin
                            pc_r     <= pc_r + WORD_SIZE'(1);
                            address1 <= pc_r + WORD_SIZE'(1);
                            if (slot_free_s) begin
                                if_valid   <= 1'b1;
                                if_instr   <= data1;
                                if_pc      <= pc_r;
                                if_pc_next <= pc_r + WORD_SIZE'(1);
                                readM1     <= 1'b1;
                            end else begin
                                // Data parked in the skid buffer; no new request.
                                state_r <= FS_SKID;
                                readM1  <= 1'b0;
                            end
                        end else if (consume_s) begin
                            if_valid <= 1'b0;
                        end else begin
                            if_valid <= if_valid;
                        end
                    end
                    FS_SKID: begin
                        if (!skid_full_s) begin
                            // Defensive recovery: nothing parked, resume fetching.
                            state_r  <= FS_FETCH;
                            readM1   <= 1'b1;
                            address1 <= pc_r;
                        end else if (!id_stall) begin
                            if_valid   <= 1'b1;
                            if_instr   <= skid_instr_s;
                            if_pc      <= skid_pc_s;
                            if_pc_next <= skid_pc_s + WORD_SIZE'(1);
                            state_r    <= FS_FETCH;
                            readM1     <= 1'b1;
                            address1   <= pc_r;
                        end else begin
                            readM1 <= 1'b0;
                        end
                    end
                    FS_KILL: begin
                        if (mem_ready) begin
                            if (halt_pending_r) begin
                                state_r        <= FS_HALT;
                                readM1         <= 1'b0;
                                is_halted      <= 1'b1;
                                halt_pending_r <= 1'b0;
                            end else begin
                                state_r  <= FS_FETCH;
                                readM1   <= 1'b1;
                                address1 <= pc_r;
                            end
                        end else begin
                            readM1 <= 1'b1;
                        end
                    end
                    FS_HALT: begin
                        readM1    <= 1'b0;
                        if_valid  <= 1'b0;
                        is_halted <= 1'b1;
                    end
                    default: begin
                        state_r  <= FS_IDLE;
                        readM1   <= 1'b0;
                        if_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A program-order scoreboard (expected
// next PC, expected consume count) checks every instruction ID accepts,
// plus memory-address stability, output freezing under stall and halt.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        readM1;
    logic [15:0] address1;
    logic [15:0] data1;
    logic        mem_ready;
    logic        id_stall;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        halt;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_next;
    logic [15:0] num_fetched;
    logic        is_halted;

    logic [15:0] mem [0:255];

    int          checks = 0;
    int          failures = 0;

    logic [15:0] exp_pc;
    logic [15:0] exp_count;
    logic        exp_halted;
    logic        hold_prev;
    logic [15:0] hold_instr, hold_pc, hold_pcn;
    logic        pend_prev;
    logic [15:0] pend_addr;

    always #5 Clk = ~Clk;

    assign data1 = mem_ready ? mem[address1[7:0]] : 16'hDEAD;

    fetch_unit dut (
        .Clk             (Clk),
        .Reset_N         (Reset_N),
        .readM1          (readM1),
        .address1        (address1),
        .data1           (data1),
        .mem_ready       (mem_ready),
        .id_stall        (id_stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_next      (if_pc_next),
        .num_fetched     (num_fetched),
        .is_halted       (is_halted)
    );

    task automatic reset_model();
        exp_pc     = 16'h0000;
        exp_count  = 16'h0000;
        exp_halted = 1'b0;
        hold_prev  = 1'b0;
        pend_prev  = 1'b0;
    endtask

    // One clock: checks at the falling edge against the model, then the
    // model advances by what the rising edge will do. Returns at posedge+1.
    task automatic cycle();
        @(negedge Clk);
        checks++;
        if (num_fetched !== exp_count)
            $display("FAIL num_fetched: got %h expected %h", num_fetched, exp_count);
        if (num_fetched !== exp_count) failures++;
        checks++;
        if (is_halted !== exp_halted) begin
            failures++;
            $display("FAIL is_halted: got %b expected %b", is_halted, exp_halted);
        end
        if (exp_halted) begin
            checks++;
            if (readM1 !== 1'b0 || if_valid !== 1'b0) begin
                failures++;
                $display("FAIL halt_quiet: got readM1=%b if_valid=%b expected 0 0", readM1, if_valid);
            end
        end
        if (pend_prev) begin
            checks++;
            if (readM1 !== 1'b1 || address1 !== pend_addr) begin
                failures++;
                $display("FAIL addr_hold: got readM1=%b addr=%h expected 1 %h", readM1, address1, pend_addr);
            end
        end
        if (hold_prev) begin
            checks++;
            if ({if_valid, if_instr, if_pc, if_pc_next} !== {1'b1, hold_instr, hold_pc, hold_pcn}) begin
                failures++;
                $display("FAIL freeze: got v=%b i=%h pc=%h pcn=%h expected 1 %h %h %h",
                         if_valid, if_instr, if_pc, if_pc_next, hold_instr, hold_pc, hold_pcn);
            end
        end
        if (if_valid && !id_stall && !(redirect && !exp_halted)) begin
            checks++;
            if ({if_pc, if_instr, if_pc_next} !== {exp_pc, mem[exp_pc[7:0]], exp_pc + 16'd1}) begin
                failures++;
                $display("FAIL consume: got pc=%h instr=%h pcn=%h expected %h %h %h",
                         if_pc, if_instr, if_pc_next, exp_pc, mem[exp_pc[7:0]], exp_pc + 16'd1);
            end
            exp_pc    = exp_pc + 16'd1;
            exp_count = exp_count + 16'd1;
        end
        if (redirect && !exp_halted) exp_pc = redirect_target;
        pend_prev  = readM1 && !mem_ready;
        pend_addr  = address1;
        hold_prev  = if_valid && id_stall && !redirect && !halt;
        hold_instr = if_instr;
        hold_pc    = if_pc;
        hold_pcn   = if_pc_next;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({readM1, address1, if_valid, if_instr, if_pc, if_pc_next, num_fetched, is_halted} !== 83'd0) begin
            failures++;
            $display("FAIL %s: got rd=%b a=%h v=%b i=%h pc=%h pcn=%h n=%h h=%b expected all zero", name,
                     readM1, address1, if_valid, if_instr, if_pc, if_pc_next, num_fetched, is_halted);
        end
    endtask

    // Assert reset, check reset values, release between clock edges.
    task automatic apply_reset();
        Reset_N = 1'b0;
        redirect = 1'b0;
        redirect_target = 16'h0000;
        halt = 1'b0;
        id_stall = 1'b0;
        #2;
        check_reset_values("reset_state");
        reset_model();
        @(posedge Clk);
        #1;
        Reset_N = 1'b1;
    endtask

    task automatic test_streaming();
        mem_ready = 1'b1;
        apply_reset();
        checks++;
        if (if_valid !== 1'b0 || readM1 !== 1'b0) begin
            failures++;
            $display("FAIL stream_idle: got v=%b rd=%b expected 0 0", if_valid, readM1);
        end
        cycle();
        checks++;
        if (readM1 !== 1'b1 || address1 !== 16'h0000 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_first_req: got rd=%b a=%h v=%b expected 1 0000 0", readM1, address1, if_valid);
        end
        cycle();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h6001) begin
            failures++;
            $display("FAIL stream_first_valid: got v=%b pc=%h i=%h expected 1 0000 6001", if_valid, if_pc, if_instr);
        end
        repeat (4) cycle();
        checks++;
        if (num_fetched !== 16'd4) begin
            failures++;
            $display("FAIL stream_count: got %0d expected 4", num_fetched);
        end
    endtask

    task automatic test_wait_states();
        logic prev_rdy;
        mem_ready = 1'b0;
        apply_reset();
        cycle();
        prev_rdy = 1'b0;
        for (int i = 0; i < 18; i++) begin
            mem_ready = (i % 3 == 2);
            checks++;
            if (if_valid !== prev_rdy) begin
                failures++;
                $display("FAIL wait_valid: step %0d got %b expected %b", i, if_valid, prev_rdy);
            end
            prev_rdy = mem_ready;
            cycle();
        end
    endtask

    task automatic test_stall_skid();
        mem_ready = 1'b1;
        apply_reset();
        id_stall = 1'b1;
        cycle();
        cycle();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h6001) begin
            failures++;
            $display("FAIL skid_first: got v=%b pc=%h i=%h expected 1 0000 6001", if_valid, if_pc, if_instr);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (readM1 !== 1'b0 || if_pc !== 16'h0000) begin
                failures++;
                $display("FAIL skid_hold: step %0d got rd=%b pc=%h expected 0 0000", i, readM1, if_pc);
            end
        end
        id_stall = 1'b0;
        cycle();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0001 || if_instr !== 16'h6102 ||
            readM1 !== 1'b1 || address1 !== 16'h0002) begin
            failures++;
            $display("FAIL skid_release: got v=%b pc=%h i=%h rd=%b a=%h expected 1 0001 6102 1 0002",
                     if_valid, if_pc, if_instr, readM1, address1);
        end
        repeat (3) cycle();
    endtask

    task automatic test_redirect_kill();
        bit found;
        mem_ready = 1'b1;
        apply_reset();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (readM1 && address1 == 16'h0005) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL kill_reach5: got addr=%h expected request to 0005", address1);
        end
        mem_ready = 1'b0;
        redirect = 1'b1;
        redirect_target = 16'h0040;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (readM1 !== 1'b1 || address1 !== 16'h0005 || if_valid !== 1'b0) begin
                failures++;
                $display("FAIL kill_hold: got rd=%b a=%h v=%b expected 1 0005 0", readM1, address1, if_valid);
            end
            if (i == 1) mem_ready = 1'b1;
            cycle();
        end
        checks++;
        if (readM1 !== 1'b1 || address1 !== 16'h0040 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL kill_target: got rd=%b a=%h v=%b expected 1 0040 0", readM1, address1, if_valid);
        end
        repeat (4) cycle();
    endtask

    task automatic test_redirect_wrap();
        mem_ready = 1'b1;
        apply_reset();
        repeat (3) cycle();
        redirect = 1'b1;
        redirect_target = 16'hFFFE;
        cycle();
        redirect = 1'b0;
        checks++;
        if (readM1 !== 1'b1 || address1 !== 16'hFFFE) begin
            failures++;
            $display("FAIL wrap_target: got rd=%b a=%h expected 1 fffe", readM1, address1);
        end
        repeat (5) cycle();
    endtask

    task automatic test_halt();
        mem_ready = 1'b1;
        apply_reset();
        repeat (4) cycle();
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        exp_halted = 1'b1;
        checks++;
        if (is_halted !== 1'b1 || readM1 !== 1'b0) begin
            failures++;
            $display("FAIL halt_direct: got h=%b rd=%b expected 1 0", is_halted, readM1);
        end
        repeat (3) cycle();
        redirect = 1'b1;
        redirect_target = 16'h0010;
        cycle();
        redirect = 1'b0;
        repeat (2) cycle();

        apply_reset();
        mem_ready = 1'b1;
        repeat (3) cycle();
        mem_ready = 1'b0;
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        checks++;
        if (is_halted !== 1'b0 || readM1 !== 1'b1) begin
            failures++;
            $display("FAIL halt_pending: got h=%b rd=%b expected 0 1", is_halted, readM1);
        end
        cycle();
        mem_ready = 1'b1;
        cycle();
        exp_halted = 1'b1;
        checks++;
        if (is_halted !== 1'b1 || readM1 !== 1'b0) begin
            failures++;
            $display("FAIL halt_after_read: got h=%b rd=%b expected 1 0", is_halted, readM1);
        end
        repeat (3) cycle();
    endtask

    task automatic test_halt_redirect();
        mem_ready = 1'b1;
        apply_reset();
        repeat (4) cycle();
        halt = 1'b1;
        redirect = 1'b1;
        redirect_target = 16'h0080;
        cycle();
        halt = 1'b0;
        redirect = 1'b0;
        checks++;
        if (is_halted !== 1'b0 || readM1 !== 1'b1 || address1 !== 16'h0080) begin
            failures++;
            $display("FAIL halt_redirect: got h=%b rd=%b a=%h expected 0 1 0080", is_halted, readM1, address1);
        end
        repeat (4) cycle();
    endtask

    task automatic test_async_reset();
        mem_ready = 1'b1;
        apply_reset();
        repeat (3) cycle();
        mem_ready = 1'b0;
        cycle();
        #2;
        Reset_N = 1'b0;
        #1;
        check_reset_values("async_reset");
        reset_model();
        mem_ready = 1'b1;
        @(posedge Clk);
        #1;
        Reset_N = 1'b1;
        cycle();
        cycle();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0000) begin
            failures++;
            $display("FAIL async_restart: got v=%b pc=%h expected 1 0000", if_valid, if_pc);
        end
        repeat (3) cycle();
    endtask

    task automatic test_random();
        mem_ready = 1'b1;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            mem_ready       = ($urandom_range(0, 2) != 0);
            id_stall        = ($urandom_range(0, 3) == 0);
            redirect        = ($urandom_range(0, 19) == 0);
            redirect_target = 16'($urandom);
            halt            = 1'b0;
            cycle();
        end
        redirect = 1'b0;
        id_stall = 1'b0;
        mem_ready = 1'b1;
        repeat (5) cycle();
    endtask

    initial begin
        Reset_N = 1'b1;
        mem_ready = 1'b0;
        id_stall = 1'b0;
        redirect = 1'b0;
        redirect_target = 16'h0000;
        halt = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h6001;
        mem[1] = 16'h6102;
        mem[2] = 16'hF01C;
        mem[3] = 16'h4000;
        #1;
        test_streaming();
        test_wait_states();
        test_stall_skid();
        test_redirect_kill();
        test_redirect_wrap();
        test_halt();
        test_halt_redirect();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
